// File: rtl/rr_arbiter4.sv
// Four-requester arbiter with a per-owner hold limit and a mandatory idle cycle between owners.
// Define ARB_ROUND_ROBIN_EN for round-robin selection; the default build uses fixed priority (req[3] highest).
module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       forced
);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_gnt;
    logic [3:0] w_gnt_nxt;
    logic [1:0] r_gnt_id;
    logic [1:0] w_gnt_id_nxt;
    logic       r_valid;
    logic       w_valid_nxt;
    logic       r_forced;
    logic       w_forced_nxt;
    logic [7:0] r_hold;
    logic [7:0] w_hold_nxt;
    logic [1:0] w_winner;
    logic       w_any;

    assign w_any = |req;

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] r_last;
    logic [1:0] w_cand;
    logic       w_found;

    // Search ascends from the slot after the last owner and wraps.
    always_comb begin
        w_winner = r_last;
        w_found  = 1'b0;
        w_cand   = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            w_cand = 2'(r_last + 2'(k));
            if (!w_found && req[w_cand]) begin
                w_winner = w_cand;
                w_found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 2'd3;
        end else if (r_state == S_IDLE && w_any) begin
            r_last <= w_winner;
        end
    end
`else
    always_comb begin
        if (req[3])      w_winner = 2'd3;
        else if (req[2]) w_winner = 2'd2;
        else if (req[1]) w_winner = 2'd1;
        else             w_winner = 2'd0;
    end
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_gnt_id_nxt = r_gnt_id;
        w_valid_nxt  = r_valid;
        w_forced_nxt = 1'b0;
        w_hold_nxt   = r_hold;
        if (r_state == S_IDLE) begin
            if (w_any) begin
                w_state_nxt  = S_GRANT;
                w_gnt_nxt    = 4'b0001 << w_winner;
                w_gnt_id_nxt = w_winner;
                w_valid_nxt  = 1'b1;
                w_hold_nxt   = '0;
            end
        end else begin
            // Both release paths land in IDLE so owners never switch directly.
            if (!req[r_gnt_id]) begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
                w_valid_nxt = 1'b0;
                w_hold_nxt  = '0;
            end else if (r_hold == 8'(MAX_HOLD - 1)) begin
                w_state_nxt  = S_IDLE;
                w_gnt_nxt    = '0;
                w_valid_nxt  = 1'b0;
                w_hold_nxt   = '0;
                w_forced_nxt = 1'b1;
            end else begin
                w_hold_nxt = r_hold + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_valid  <= 1'b0;
            r_forced <= 1'b0;
            r_hold   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_valid  <= w_valid_nxt;
            r_forced <= w_forced_nxt;
            r_hold   <= w_hold_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_valid;
    assign forced    = r_forced;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: directed scenarios with literal expectations plus random traffic
// compared every cycle against an owner/run-length model of the arbitration rules.
module tb_rr_arbiter4;

    localparam int unsigned MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       forced;

    int checks = 0;
    int errors = 0;

    rr_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .gnt(gnt),
        .gnt_id(gnt_id),
        .gnt_valid(gnt_valid),
        .forced(forced)
    );

    always #5 clk = ~clk;

    // Model: owner is -1 when idle; run counts cycles the current owner has held the grant.
    int m_owner  = -1;
    int m_id     = 0;
    int m_rrlast = 3;
    int m_run    = 0;
    bit m_forced = 1'b0;

    function automatic int pick(input logic [3:0] r, input int last);
        int w;
        w = -1;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= 4; k++)
            if (w < 0 && r[(last + k) % 4]) w = (last + k) % 4;
`else
        for (int c = 3; c >= 0; c--)
            if (w < 0 && r[c]) w = c;
`endif
        return w;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner  = -1;
            m_id     = 0;
            m_rrlast = 3;
            m_run    = 0;
            m_forced = 1'b0;
        end else begin
            m_forced = 1'b0;
            if (m_owner < 0) begin
                if (req != 4'b0000) begin
                    m_owner  = pick(req, m_rrlast);
                    m_id     = m_owner;
                    m_rrlast = m_owner;
                    m_run    = 1;
                end
            end else if (!req[m_owner]) begin
                m_owner = -1;
            end else if (m_run == MAX_HOLD) begin
                m_owner  = -1;
                m_forced = 1'b1;
            end else begin
                m_run++;
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("model_gnt", gnt, (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner));
        chk("model_gnt_id", {2'b00, gnt_id}, 4'(m_id));
        chk("model_gnt_valid", {3'b000, gnt_valid}, {3'b000, (m_owner >= 0)});
        chk("model_forced", {3'b000, forced}, {3'b000, m_forced});
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_g;
        int blk;
        int pos;

        do_reset();
        chk("reset_gnt", gnt, 4'b0000);
        chk("reset_id", {2'b00, gnt_id}, 4'b0000);
        chk("reset_valid", {3'b000, gnt_valid}, 4'b0000);

        // Single requester held for three sampled edges.
        req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                step();
                req = 4'b0000;
            end else begin
                step();
            end
            chk("single_gnt", gnt, 4'b0001);
            chk("single_forced", {3'b000, forced}, 4'b0000);
        end
        step();
        chk("single_release", gnt, 4'b0000);
        chk("single_release_id", {2'b00, gnt_id}, 4'b0000);
        chk("single_release_forced", {3'b000, forced}, 4'b0000);

        // All requesting: hold limit forces a release with one idle cycle between grants.
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 45; k++) begin
            step();
            blk = k / 9;
            pos = k % 9;
`ifdef ARB_ROUND_ROBIN_EN
            exp_g = (pos < 8) ? (4'b0001 << (blk % 4)) : 4'b0000;
`else
            exp_g = (pos < 8) ? 4'b1000 : 4'b0000;
`endif
            chk("saturate_gnt", gnt, exp_g);
            chk("saturate_forced", {3'b000, forced}, (pos == 8) ? 4'b0001 : 4'b0000);
        end

        // Owner 2 drops out while 3, 1, 0 are waiting.
        do_reset();
        req = 4'b0100;
        step();
        chk("drop_owner2", gnt, 4'b0100);
        req = 4'b1011;
        step();
        chk("drop_idle", gnt, 4'b0000);
        chk("drop_idle_id", {2'b00, gnt_id}, 4'b0010);
        step();
        chk("drop_next", gnt, 4'b1000);
        req = 4'b0011;
        step();
        chk("drop_idle2", gnt, 4'b0000);
        step();
`ifdef ARB_ROUND_ROBIN_EN
        chk("drop_after", gnt, 4'b0001);
`else
        chk("drop_after", gnt, 4'b0010);
`endif

        // Asynchronous reset between edges during a grant.
        do_reset();
        req = 4'b0100;
        step();
        chk("areset_pre", gnt, 4'b0100);
        #3 rst = 1'b1;
        #1;
        chk("areset_gnt", gnt, 4'b0000);
        chk("areset_valid", {3'b000, gnt_valid}, 4'b0000);
        chk("areset_id", {2'b00, gnt_id}, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0110;
        step();
`ifdef ARB_ROUND_ROBIN_EN
        chk("areset_first", gnt, 4'b0010);
`else
        chk("areset_first", gnt, 4'b0100);
`endif

        // Short request from a non-owner must never be served.
        do_reset();
        req = 4'b0001;
        step();
        chk("pulse_owner", gnt, 4'b0001);
        req = 4'b0011;
        step();
        chk("pulse_hold1", gnt, 4'b0001);
        step();
        chk("pulse_hold2", gnt, 4'b0001);
        req = 4'b0001;
        step();
        chk("pulse_hold3", gnt, 4'b0001);
        req = 4'b0000;
        step();
        chk("pulse_end", gnt, 4'b0000);
        step();
        chk("pulse_never", gnt, 4'b0000);

        // Random traffic with sticky requests and occasional asynchronous resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rst) begin
                rst = 1'b0;
            end else begin
                for (int b = 0; b < 4; b++)
                    if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
                if ($urandom_range(0, 199) == 0) begin
                    #3 rst = 1'b1;
                end
            end
        end
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
